// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath types, state encoding and byte helpers
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column c occupies block[127-32c -: 32]; row 0 is the column's MSB byte.
  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
    return s[127 - 32 * int'(c) -: 32];
  endfunction

  function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] c,
                                           input logic [31:0] v);
    logic [127:0] r;
    r = s;
    r[127 - 32 * int'(c) -: 32] = v;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] col, input logic [1:0] row);
    return col[31 - 8 * int'(row) -: 8];
  endfunction

endpackage

// File: rtl/mix_column.sv
// rtl/mix_column.sv - combinational MixColumns / InvMixColumns on one 32-bit column
module mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  for (genvar r = 0; r < 4; r++) begin : g_mul
    assign a[r]  = get_byte(col_in, 2'(r));
    assign x2[r] = xtime(a[r]);
    assign x4[r] = xtime(x2[r]);
    assign x8[r] = xtime(x4[r]);
    assign m9[r] = x8[r] ^ a[r];
    assign mb[r] = x8[r] ^ x2[r] ^ a[r];
    assign md[r] = x8[r] ^ x4[r] ^ a[r];
    assign me[r] = x8[r] ^ x4[r] ^ x2[r];
  end

  // Each row uses the coefficient vector rotated right by its row index.
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;
    assign col_out[31-8*r -: 8] = inv
      ? (me[r] ^ mb[R1] ^ md[R2] ^ m9[R3])
      : (x2[r] ^ x2[R1] ^ a[R1] ^ a[R2] ^ a[R3]);
  end

endmodule

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - column-serial MixColumns stage with valid/ready handshakes
module mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] block,
  input  logic         inv,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] new_block
);

  state_t       state;
  logic [1:0]   col;
  logic         inv_q;
  logic [127:0] st;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  assign col_in    = get_col(st, col);
  assign new_block = st;

  mix_column u_mix_column (
    .col_in  (col_in),
    .inv     (inv_q),
    .col_out (col_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= 2'd0;
      inv_q     <= 1'b0;
      st        <= 128'h0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            st       <= block;
            inv_q    <= inv;
            col      <= 2'd0;
            in_ready <= 1'b0;
            // Final round skips MixColumns entirely.
            if (last_round) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          st  <= set_col(st, col, col_out);
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
